// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny hysteresis stage.
//   class_t      : 2-bit pixel class (none / weak / strong)
//   CLS_*        : class encodings
//   LAT          : input-to-output latency in clocks
package canny_pkg;

    typedef logic [1:0] class_t;

    localparam class_t CLS_NONE   = 2'd0;
    localparam class_t CLS_WEAK   = 2'd1;
    localparam class_t CLS_STRONG = 2'd2;

    localparam int unsigned LAT = 3;

    function automatic logic is_strong(input class_t c);
        return c == CLS_STRONG;
    endfunction

endpackage

// File: rtl/canny_class_line_buffer.sv
// Two-line class buffer plus column shift that presents a border-masked 3x3
// window (rows r-2..r, cols c-2..c) of pixel classes.
// Ports:
//   clk, rst_s     : clock, synchronous active-high reset
//   wr_en          : a valid pixel class is presented this cycle
//   col            : column of the presented pixel
//   top_ok, mid_ok : rows r-2 / r-1 exist (row >= 2 / row >= 1)
//   cls_in         : class of the presented pixel
//   taps           : registered window, index = row*3 + col (row 0 = r-2, col 0 = c-2)
module canny_class_line_buffer
    import canny_pkg::*;
#(
    parameter int unsigned IMG_W = 640
) (
    input  logic                         clk,
    input  logic                         rst_s,
    input  logic                         wr_en,
    input  logic [$clog2(IMG_W + 1)-1:0] col,
    input  logic                         top_ok,
    input  logic                         mid_ok,
    input  class_t                       cls_in,
    output class_t [8:0]                 taps
);

    localparam int unsigned COL_W  = $clog2(IMG_W + 1);
    localparam int unsigned ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // line0 holds row r-1, line1 holds row r-2 (RAM is not reset)
    class_t line0 [IMG_W];
    class_t line1 [IMG_W];

    // raw column history: sr_b = column c-1, sr_a = column c-2; [0]=top,[2]=bottom
    class_t [2:0] sr_a;
    class_t [2:0] sr_b;

    logic [ADDR_W-1:0] addr_c;
    class_t            rd0_c;
    class_t            rd1_c;
    class_t [2:0]      new_col_c;
    class_t [8:0]      win_c;
    logic              left_ok_c;
    logic              cmid_ok_c;

    // address is only meaningful on write cycles; park it at 0 otherwise
    always_comb begin
        addr_c = '0;
        if (wr_en) begin
            addr_c = ADDR_W'(col);
        end
    end

    assign rd0_c     = line0[addr_c];
    assign rd1_c     = line1[addr_c];
    assign new_col_c = {cls_in, rd0_c, rd1_c};
    assign left_ok_c = (col >= COL_W'(2));
    assign cmid_ok_c = (col >= COL_W'(1));

    // assemble the next window and blank taps that fall outside the frame
    always_comb begin
        win_c    = '0;
        win_c[0] = (top_ok && left_ok_c) ? sr_a[0] : CLS_NONE;
        win_c[1] = (top_ok && cmid_ok_c) ? sr_b[0] : CLS_NONE;
        win_c[2] = top_ok                ? new_col_c[0] : CLS_NONE;
        win_c[3] = (mid_ok && left_ok_c) ? sr_a[1] : CLS_NONE;
        win_c[4] = (mid_ok && cmid_ok_c) ? sr_b[1] : CLS_NONE;
        win_c[5] = mid_ok                ? new_col_c[1] : CLS_NONE;
        win_c[6] = left_ok_c             ? sr_a[2] : CLS_NONE;
        win_c[7] = cmid_ok_c             ? sr_b[2] : CLS_NONE;
        win_c[8] = new_col_c[2];
    end

    // read-before-write: the old row r-1 value cascades into the r-2 line
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line0[addr_c] <= cls_in;
            line1[addr_c] <= rd0_c;
        end
    end

    // column shift and registered window
    always_ff @(posedge clk) begin
        if (rst_s) begin
            sr_a <= '0;
            sr_b <= '0;
            taps <= '0;
        end else if (wr_en) begin
            sr_a <= sr_b;
            sr_b <= new_col_c;
            taps <= win_c;
        end
    end

endmodule

// File: rtl/canny_hysteresis_param.sv
// Double-threshold classification and hysteresis edge decision over a 3x3
// class window, with 4/8-connectivity and frame-shadowed configuration.
// Ports:
//   clk, rst_s               : clock, synchronous active-high reset
//   per_frame_vsync/href/clken, per_img_mag : input video timing and magnitude
//   cfg_thr_low/high, cfg_conn8 : thresholds and connectivity, taken at vsync rise
//   post_frame_vsync/href/clken : input timing delayed by LAT
//   post_img_edge, post_img_class : edge result and centre class for the slot
module canny_hysteresis_param
    import canny_pkg::*;
#(
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned MAG_W    = 8,
    parameter int unsigned DEF_LOW  = 40,
    parameter int unsigned DEF_HIGH = 80
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [MAG_W-1:0] per_img_mag,
    input  logic [MAG_W-1:0] cfg_thr_low,
    input  logic [MAG_W-1:0] cfg_thr_high,
    input  logic             cfg_conn8,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic             post_img_edge,
    output class_t           post_img_class
);

    localparam int unsigned COL_W = $clog2(IMG_W + 1);
    localparam int unsigned ROW_W = 12;

    // timing delay lines; index 0 doubles as the previous-cycle sample
    logic [LAT-1:0] vs_d;
    logic [LAT-1:0] hr_d;
    logic [LAT-1:0] ck_d;

    logic [MAG_W-1:0] thr_low_q;
    logic [MAG_W-1:0] thr_high_q;
    logic             conn8_q;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    logic   vsync_rise_c;
    logic   href_fall_c;
    logic   pix_ok_c;
    class_t cls_c;

    logic             s1_valid;
    class_t           s1_cls;
    logic [COL_W-1:0] s1_col;
    logic             s1_top_ok;
    logic             s1_mid_ok;
    logic             s1_slot_ok;

    logic         s2_valid;
    logic         s2_slot_ok;
    class_t [8:0] taps;

    logic nb4_c;
    logic diag_c;
    logic edge_c;

    assign vsync_rise_c = per_frame_vsync & ~vs_d[0];
    assign href_fall_c  = hr_d[0] & ~per_frame_href;
    // a vsync rise wins over a coincident pixel
    assign pix_ok_c     = per_frame_href & per_frame_clken & ~vsync_rise_c
                          & (col_q < COL_W'(IMG_W));

    // strong is tested first so it wins even when low > high
    always_comb begin
        cls_c = CLS_NONE;
        if (per_img_mag >= thr_high_q) begin
            cls_c = CLS_STRONG;
        end else if (per_img_mag >= thr_low_q) begin
            cls_c = CLS_WEAK;
        end
    end

    // timing delay lines
    always_ff @(posedge clk) begin
        if (rst_s) begin
            vs_d <= '0;
            hr_d <= '0;
            ck_d <= '0;
        end else begin
            vs_d <= {vs_d[LAT-2:0], per_frame_vsync};
            hr_d <= {hr_d[LAT-2:0], per_frame_href};
            ck_d <= {ck_d[LAT-2:0], per_frame_clken};
        end
    end

    // configuration shadow, loaded only on vsync rise
    always_ff @(posedge clk) begin
        if (rst_s) begin
            thr_low_q  <= MAG_W'(DEF_LOW);
            thr_high_q <= MAG_W'(DEF_HIGH);
            conn8_q    <= 1'b1;
        end else if (vsync_rise_c) begin
            thr_low_q  <= cfg_thr_low;
            thr_high_q <= cfg_thr_high;
            conn8_q    <= cfg_conn8;
        end
    end

    // row/column position of the incoming pixel; col saturates at IMG_W
    always_ff @(posedge clk) begin
        if (rst_s) begin
            col_q <= '0;
            row_q <= '0;
        end else if (vsync_rise_c) begin
            col_q <= '0;
            row_q <= '0;
        end else if (href_fall_c) begin
            col_q <= '0;
            if (row_q != {ROW_W{1'b1}}) begin
                row_q <= row_q + ROW_W'(1);
            end
        end else if (per_frame_href && per_frame_clken && (col_q < COL_W'(IMG_W))) begin
            col_q <= col_q + COL_W'(1);
        end
    end

    // stage 1: class plus position flags
    always_ff @(posedge clk) begin
        if (rst_s) begin
            s1_valid   <= 1'b0;
            s1_cls     <= CLS_NONE;
            s1_col     <= '0;
            s1_top_ok  <= 1'b0;
            s1_mid_ok  <= 1'b0;
            s1_slot_ok <= 1'b0;
        end else begin
            s1_valid   <= pix_ok_c;
            s1_cls     <= cls_c;
            s1_col     <= col_q;
            s1_top_ok  <= (row_q >= ROW_W'(2));
            s1_mid_ok  <= (row_q >= ROW_W'(1));
            s1_slot_ok <= (row_q != '0) && (col_q != '0);
        end
    end

    // stage 2: window formation
    canny_class_line_buffer #(
        .IMG_W (IMG_W)
    ) u_line_buffer (
        .clk    (clk),
        .rst_s  (rst_s),
        .wr_en  (s1_valid),
        .col    (s1_col),
        .top_ok (s1_top_ok),
        .mid_ok (s1_mid_ok),
        .cls_in (s1_cls),
        .taps   (taps)
    );

    always_ff @(posedge clk) begin
        if (rst_s) begin
            s2_valid   <= 1'b0;
            s2_slot_ok <= 1'b0;
        end else begin
            s2_valid   <= s1_valid;
            s2_slot_ok <= s1_slot_ok;
        end
    end

    // hysteresis decision on the window centre (tap 4)
    assign nb4_c  = is_strong(taps[1]) | is_strong(taps[3])
                  | is_strong(taps[5]) | is_strong(taps[7]);
    assign diag_c = is_strong(taps[0]) | is_strong(taps[2])
                  | is_strong(taps[6]) | is_strong(taps[8]);
    assign edge_c = (taps[4] != CLS_NONE)
                  && (is_strong(taps[4]) || nb4_c || (conn8_q && diag_c));

    // stage 3: result updates only on delayed-clken cycles
    always_ff @(posedge clk) begin
        if (rst_s) begin
            post_img_edge  <= 1'b0;
            post_img_class <= CLS_NONE;
        end else if (ck_d[LAT-2]) begin
            if (s2_valid && s2_slot_ok) begin
                post_img_edge  <= edge_c;
                post_img_class <= taps[4];
            end else begin
                post_img_edge  <= 1'b0;
                post_img_class <= CLS_NONE;
            end
        end
    end

    assign post_frame_vsync = vs_d[LAT-1];
    assign post_frame_href  = hr_d[LAT-1];
    assign post_frame_clken = ck_d[LAT-1];

endmodule

// File: doc/canny_hysteresis_param.md
Name: canny_hysteresis_param

Overview:
Parametrised double-threshold/hysteresis stage for the Canny pipeline; successor to the fixed 2-bit-class threshold block.
- Accepts raw NMS gradient magnitude rather than a pre-classified class.
- Classifies each pixel against runtime low/high thresholds, buffers two lines of classes internally, and applies selectable 4- or 8-connectivity.
- Sits between non-max suppression and the binary edge output; drives vsync/href/clken aligned to its result.

Parameters:
IMG_W, 640, max active pixels per line (line-buffer depth)
MAG_W, 8, gradient magnitude width
DEF_LOW, 40, low threshold loaded at reset
DEF_HIGH, 80, high threshold loaded at reset

Ports:
clk  in  1  pixel clock
rst_s  in  1  synchronous active-high reset
per_frame_vsync  in  1  input frame sync
per_frame_href  in  1  input line valid
per_frame_clken  in  1  input pixel strobe
per_img_mag  in  MAG_W  NMS gradient magnitude
cfg_thr_low  in  MAG_W  low threshold, shadowed
cfg_thr_high  in  MAG_W  high threshold, shadowed
cfg_conn8  in  1  1 = 8-connectivity, 0 = 4-connectivity, shadowed
post_frame_vsync  out  1  vsync delayed by LAT
post_frame_href  out  1  href delayed by LAT
post_frame_clken  out  1  clken delayed by LAT
post_img_edge  out  1  binary edge result
post_img_class  out  2  class of window centre (debug)

Behaviour:
- Clock and reset: one clock (clk). Reset rst_s is synchronous and active-high.
- Reset values: all outputs 0; sync delay lines 0; active thresholds = DEF_LOW/DEF_HIGH; active conn8 = 1; row/col counters 0. Line-buffer RAM is not cleared.
- Shadowing: cfg_* are copied to active registers only on the cycle where per_frame_vsync rises (0→1). Changes mid-frame have no effect until the next frame.
- Classification, stage 1, registered:
  - class = 2 if mag >= thr_high; else 1 if mag >= thr_low; else 0.
  - Strong has priority, so if thr_low > thr_high then mag >= thr_high is still class 2.
  - Unsigned compare at MAG_W bits.
- Counters:
  - col increments per clken while href = 1; clears when href falls.
  - row increments when href falls; clears when vsync rises.
  - col saturates at IMG_W: pixels with col >= IMG_W are not written and output edge = 0.
- Line buffers: two IMG_W x 2-bit lines, read-before-write at the same address on each stage-1 valid pixel. Together with two column shift registers they form a 3x3 window over rows r-2..r and columns c-2..c. The window centre is (r-1, c-1).
- Border handling:
  - Window taps with row < 0 (r = 1) or col < 0 (c = 1) read as class 0.
  - Output slots with r = 0 or c = 0 carry edge = 0 and class = 0.
- Decision, stage 3, registered:
  - edge = (centre != 0) && (centre == 2 || any selected neighbour == 2).
  - Selected neighbours are all 8 if conn8, else N/S/E/W only.
- Latency: LAT = 3 clocks. post_* syncs are the exact per_* inputs delayed 3 cycles. Data is updated only on delayed-clken cycles and holds otherwise.
- Reset mid-frame: pipeline and counters clear immediately. Output stays 0 until href timing resumes; the next vsync rise restarts cleanly.
- Simultaneous vsync rise and href: vsync rise takes precedence for counter clear and shadow load.

Decomposition:
- Package canny_pkg holds:
  - class encodings CLS_NONE = 0, CLS_WEAK = 1, CLS_STRONG = 2;
  - localparam LAT = 3;
  - a 2-bit class typedef.
- One sub-module, canny_class_line_buffer: dual-line 2-bit RAM plus column shift, outputting 9 window taps. It is parametrised by IMG_W.

Test Plan:
1. Thresholds 40/80, 8-conn, 8x8 frame, centre (3,3) mag 50, neighbour (2,2) mag 90, rest 0 → edge = 1 for centre (3,3) in slot (4,4); (2,2) edge = 1; all others 0.
2. Same frame with cfg_conn8 = 0 → (3,3) edge = 0 (diagonal only); (2,2) still 1. Move the strong pixel to (2,3) → (3,3) edge = 1.
3. Write cfg_thr_high = 30 mid-frame → current frame unchanged. Next frame: mag 50 pixels classify as 2 and post_img_class = 2.
4. thr_low = 100, thr_high = 60, mag 80 → class 2, edge = 1; mag 59 → class 0.
5. Strong pixel at (0,0), weak at (1,0) → no out-of-frame taps counted; weak (1,0) edge = 1. Slot row 0 / col 0 outputs 0.
6. Assert rst_s for 2 cycles mid-line → all post_* = 0 on the cycle after reset. Thresholds revert to 40/80. Post-sync follows per-sync exactly 3 cycles later after release.
